// File: rtl/fadd_pkg.sv
// Shared constants and the per-stage record for the f-add alignment shifter.
package fadd_pkg;

  localparam int MANT_W  = 11;
  localparam int SHAMT_W = 5;
  localparam int WORD_W  = MANT_W + 2;

  // One pipeline slot: valid, working word {mant, g, r}, sticky, shift amount.
  typedef struct packed {
    logic               valid;
    logic [WORD_W-1:0]  w;
    logic               s;
    logic [SHAMT_W-1:0] diff;
  } stage_t;

  function automatic logic [WORD_W-1:0] load_word(input logic [MANT_W-1:0] m);
    return {m, 2'b00};
  endfunction

endpackage

// File: rtl/barrel_shift_r_stage.sv
// One registered layer of the right barrel shifter: conditional shift by SHIFT,
// sticky accumulation of the dropped bits, and a valid/ready slot.
module barrel_shift_r_stage #(
  parameter int SHIFT   = 1,
  parameter int MANT_W  = 11,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               up_valid_i,
  output logic               up_ready_o,
  input  logic [MANT_W+1:0]  up_w_i,
  input  logic               up_s_i,
  input  logic [SHAMT_W-1:0] up_diff_i,
  output logic               dn_valid_o,
  input  logic               dn_ready_i,
  output logic [MANT_W+1:0]  dn_w_o,
  output logic               dn_s_o,
  output logic [SHAMT_W-1:0] dn_diff_o
);

  localparam int WORD_W = MANT_W + 2;
  localparam int BIT    = $clog2(SHIFT);

  logic               valid_q;
  logic [WORD_W-1:0]  w_q;
  logic [WORD_W-1:0]  w_d;
  logic [WORD_W-1:0]  w_shifted;
  logic               s_q;
  logic               s_d;
  logic               lost;
  logic [SHAMT_W-1:0] diff_q;
  logic               advance;

  // A shift at least as wide as the word flushes everything into sticky.
  generate
    if (SHIFT >= WORD_W) begin : g_flush
      assign w_shifted = '0;
      assign lost      = |up_w_i;
    end else begin : g_shift
      assign w_shifted = up_w_i >> SHIFT;
      assign lost      = |up_w_i[SHIFT-1:0];
    end
  endgenerate

  always_comb begin
    w_d = up_w_i;
    s_d = up_s_i;
    if (up_diff_i[BIT]) begin
      w_d = w_shifted;
      s_d = up_s_i | lost;
    end
  end

  assign advance = !valid_q || dn_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      w_q     <= '0;
      s_q     <= 1'b0;
      diff_q  <= '0;
    end else if (advance) begin
      valid_q <= up_valid_i;
      // Data only moves when a real operand arrives, so idle bubbles do not toggle it.
      if (up_valid_i) begin
        w_q    <= w_d;
        s_q    <= s_d;
        diff_q <= up_diff_i;
      end
    end
  end

  assign up_ready_o = advance;
  assign dn_valid_o = valid_q;
  assign dn_w_o     = w_q;
  assign dn_s_o     = s_q;
  assign dn_diff_o  = diff_q;

endmodule

// File: rtl/barrel_shifter_r_pipe.sv
// Pipelined right barrel shifter aligning the smaller-exponent mantissa for f-add,
// producing guard, round and sticky bits; one stage per shift-amount bit.
module barrel_shifter_r_pipe
  import fadd_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SHAMT_W-1:0] diff,
  input  logic [MANT_W-1:0]  mant,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [MANT_W-1:0]  shifted_num,
  output logic               guard,
  output logic               round_bit,
  output logic               sticky
);

  stage_t             head;
  logic               v_a    [0:SHAMT_W];
  logic [WORD_W-1:0]  w_a    [0:SHAMT_W];
  logic               s_a    [0:SHAMT_W];
  logic [SHAMT_W-1:0] diff_a [0:SHAMT_W];
  logic               rdy    [0:SHAMT_W];
  logic               unused_diff;

  assign head = '{valid: in_valid, w: load_word(mant), s: 1'b0, diff: diff};

  assign v_a[0]    = head.valid;
  assign w_a[0]    = head.w;
  assign s_a[0]    = head.s;
  assign diff_a[0] = head.diff;

  assign rdy[SHAMT_W] = out_ready;
  assign in_ready     = rdy[0];

  // Stage gi shifts by 2^gi when diff[gi] is set; ready ripples back from the output.
  genvar gi;
  generate
    for (gi = 0; gi < SHAMT_W; gi++) begin : g_stage
      barrel_shift_r_stage #(
        .SHIFT   (1 << gi),
        .MANT_W  (MANT_W),
        .SHAMT_W (SHAMT_W)
      ) u_stage (
        .clk        (clk),
        .rst        (rst),
        .up_valid_i (v_a[gi]),
        .up_ready_o (rdy[gi]),
        .up_w_i     (w_a[gi]),
        .up_s_i     (s_a[gi]),
        .up_diff_i  (diff_a[gi]),
        .dn_valid_o (v_a[gi+1]),
        .dn_ready_i (rdy[gi+1]),
        .dn_w_o     (w_a[gi+1]),
        .dn_s_o     (s_a[gi+1]),
        .dn_diff_o  (diff_a[gi+1])
      );
    end
  endgenerate

  assign out_valid   = v_a[SHAMT_W];
  assign shifted_num = w_a[SHAMT_W][WORD_W-1:2];
  assign guard       = w_a[SHAMT_W][1];
  assign round_bit   = w_a[SHAMT_W][0];
  assign sticky      = s_a[SHAMT_W];

  // The shift amount has been fully consumed once it leaves the last stage.
  assign unused_diff = ^diff_a[SHAMT_W];

endmodule

// File: tb/tb_barrel_shifter_r_pipe.sv
// Directed and randomized checks of barrel_shifter_r_pipe against an arithmetic model.
module tb_barrel_shifter_r_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  diff;
  logic [10:0] mant;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] shifted_num;
  logic        guard;
  logic        round_bit;
  logic        sticky;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          n_acc = 0;
  int          n_out = 0;
  int          first_out_cyc = -1;
  int          last_out_cyc = -1;
  bit          chk_lat = 1'b0;
  bit          in_fire = 1'b0;
  logic [13:0] last_out = '0;
  logic [13:0] exp_q[$];
  int          acc_q[$];

  barrel_shifter_r_pipe dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .diff        (diff),
    .mant        (mant),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .shifted_num (shifted_num),
    .guard       (guard),
    .round_bit   (round_bit),
    .sticky      (sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Place the mantissa far above a 32-bit scratch field, shift, then read off the fields.
  function automatic logic [13:0] ref_model(input logic [10:0] m, input logic [4:0] d);
    logic [44:0] full;
    full = {m, 2'b00, 32'd0} >> d;
    return {full[44:34], full[33], full[32], |full[31:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Settle inputs, account for both handshakes, then advance one clock.
  task automatic tick();
    logic [13:0] obs;
    logic [13:0] expv;
    int          acc_c;
    #1;
    in_fire = 1'b0;
    if (!rst) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_model(mant, diff));
        acc_q.push_back(cyc);
        n_acc++;
        in_fire = 1'b1;
      end
      if (out_valid && out_ready) begin
        obs = {shifted_num, guard, round_bit, sticky};
        last_out = obs;
        n_out++;
        last_out_cyc = cyc;
        if (first_out_cyc < 0) first_out_cyc = cyc;
        check("out_has_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          expv  = exp_q.pop_front();
          acc_c = acc_q.pop_front();
          check("result", 32'(obs), 32'(expv));
          $display("out cyc=%0d shifted=%b g=%b r=%b s=%b exp=%b", cyc, shifted_num, guard,
                   round_bit, sticky, expv);
          if (chk_lat) check("latency", 32'(cyc - acc_c), 32'd5);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    for (int k = 0; k < 80 && exp_q.size() > 0; k++) tick();
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic send_directed(input string tag, input logic [10:0] m, input logic [4:0] d,
                               input logic [13:0] expv);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    mant      = m;
    diff      = d;
    tick();
    in_valid = 1'b0;
    drain();
    check(tag, 32'(last_out), 32'(expv));
  endtask

  initial begin
    logic [10:0] m4 [8];
    logic [4:0]  d4 [8];
    int          idx;
    int          start_cyc;
    int          edge_diff [4];

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mant = '0; diff = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_data", 32'({shifted_num, guard, round_bit, sticky}), 32'd0);

    // Directed alignment cases.
    chk_lat = 1'b1;
    send_directed("dir_diff0", 11'b10010010011, 5'd0, {11'b10010010011, 3'b000});
    send_directed("dir_diff3", 11'b10010010011, 5'd3, {11'b00010010010, 3'b011});
    send_directed("dir_diff31_one", 11'b00000000001, 5'd31, {11'd0, 3'b001});
    send_directed("dir_diff31_zero", 11'd0, 5'd31, 14'd0);
    send_directed("dir_diff13_full", 11'h7FF, 5'd13, {11'd0, 3'b001});
    send_directed("dir_diff12_gr", 11'b10000000000, 5'd12, {11'd0, 3'b010});

    // Backpressure: 8 offered while the output is blocked for 10 cycles.
    chk_lat = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m4[i] = 11'($urandom_range(0, 2047));
      d4[i] = 5'($urandom_range(0, 31));
    end
    n_acc = 0; n_out = 0; idx = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      mant = m4[idx];
      diff = d4[idx];
      tick();
      if (in_fire) idx++;
    end
    check("stall_accepted", 32'(n_acc), 32'd5);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    check("stall_out_valid", 32'(out_valid), 32'd1);
    check("stall_head", 32'({shifted_num, guard, round_bit, sticky}), 32'(exp_q[0]));
    out_ready = 1'b1;
    for (int k = 0; k < 40 && idx < 8; k++) begin
      in_valid = 1'b1;
      mant = m4[idx];
      diff = d4[idx];
      tick();
      if (in_fire) idx++;
    end
    in_valid = 1'b0;
    drain();
    check("stall_emitted", 32'(n_out), 32'd8);

    // Back-to-back stream of 20, including boundary shift amounts.
    edge_diff[0] = 0; edge_diff[1] = 12; edge_diff[2] = 13; edge_diff[3] = 31;
    chk_lat = 1'b1;
    n_acc = 0; n_out = 0; first_out_cyc = -1;
    start_cyc = cyc;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      mant = 11'($urandom_range(0, 2047));
      diff = (i < 4) ? 5'(edge_diff[i]) : 5'($urandom_range(0, 31));
      tick();
    end
    in_valid = 1'b0;
    drain();
    check("stream_accepted", 32'(n_acc), 32'd20);
    check("stream_emitted", 32'(n_out), 32'd20);
    check("stream_first", 32'(first_out_cyc - start_cyc), 32'd5);
    check("stream_span", 32'(last_out_cyc - first_out_cyc), 32'd19);

    // Random valid/ready traffic.
    chk_lat = 1'b0;
    n_acc = 0; n_out = 0;
    for (int i = 0; i < 200; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      mant = 11'($urandom_range(0, 2047));
      diff = 5'($urandom_range(0, 31));
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    check("random_count", 32'(n_out), 32'(n_acc));

    // Reset with three operands in flight.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      mant = 11'($urandom_range(1, 2047));
      diff = 5'($urandom_range(0, 4));
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    acc_q.delete();
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_data", 32'({shifted_num, guard, round_bit, sticky}), 32'd0);
    n_out = 0;
    for (int i = 0; i < 12; i++) tick();
    check("midrst_no_stale", 32'(n_out), 32'd0);
    chk_lat = 1'b1;
    send_directed("post_rst", 11'b10010010011, 5'd3, {11'b00010010010, 3'b011});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
